// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared state encoding and default sizing for the frequency meter
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int DEF_GATE_CYCLES = 40_000_000;
  localparam int DEF_CNT_W       = 28;

  // A one-cycle gate would give $clog2 of 0, so keep at least one bit
  function automatic int gate_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/freq_meter_sig_sync.sv
// rtl/freq_meter_sig_sync.sv - multi-flop synchronizer with registered-history rise detector
module sig_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk40,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync_out = r_sync[SYNC_STAGES-1];
  assign rise     = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter reporting input frequency once per window
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk40,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             overflow,
  output logic             no_signal
);

  localparam int                GATE_W    = gate_width(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t             r_state;
  logic [GATE_W-1:0]  r_gate;
  logic [CNT_W-1:0]   r_edge;
  logic [CNT_W-1:0]   r_count;
  logic               r_valid;
  logic               r_ovf;
  logic               r_nosig;
  logic               w_rise;
  logic               w_sync_level_unused;

  sig_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sig_sync (
    .clk40    (clk40),
    .reset_n  (reset_n),
    .async_in (sig_in),
    .sync_out (w_sync_level_unused),
    .rise     (w_rise)
  );

  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_gate  <= '0;
      r_edge  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_nosig <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_gate <= '0;
          r_edge <= '0;
          if (enable) r_state <= RUN;
        end
        RUN: begin
          r_gate <= r_gate + 1'b1;
          if (w_rise && (r_edge != CNT_MAX)) r_edge <= r_edge + 1'b1;
          if (r_gate == GATE_LAST) r_state <= LATCH;
        end
        LATCH: begin
          // Rises seen here fall into the dead cycle and are dropped
          r_count <= r_edge;
          r_ovf   <= (r_edge == CNT_MAX);
          r_nosig <= (r_edge == '0);
          r_valid <= 1'b1;
          r_gate  <= '0;
          r_edge  <= '0;
          r_state <= enable ? RUN : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign freq_count = r_count;
  assign freq_valid = r_valid;
  assign overflow   = r_ovf;
  assign no_signal  = r_nosig;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - self-checking bench for freq_meter with a short gate window
module tb_freq_meter;

  localparam int GC = 1000;

  logic        clk40   = 1'b0;
  logic        reset_n = 1'b0;
  logic        sig_in  = 1'b0;
  logic        enable  = 1'b0;
  logic [27:0] freq_count;
  logic        freq_valid, overflow, no_signal;
  logic [3:0]  s_count;
  logic        s_valid, s_ovf, s_nosig;

  int total = 0;
  int bad   = 0;
  int half  = 0;
  int gen_c = 0;

  typedef struct {
    int half;
    int cnt;
    int ovf;
    int nosig;
    int scnt;
    int sovf;
  } vec_t;

  vec_t vecs [6];

  freq_meter #(.GATE_CYCLES(GC)) dut (
    .clk40      (clk40),
    .reset_n    (reset_n),
    .sig_in     (sig_in),
    .enable     (enable),
    .freq_count (freq_count),
    .freq_valid (freq_valid),
    .overflow   (overflow),
    .no_signal  (no_signal)
  );

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(4)) dut_small (
    .clk40      (clk40),
    .reset_n    (reset_n),
    .sig_in     (sig_in),
    .enable     (enable),
    .freq_count (s_count),
    .freq_valid (s_valid),
    .overflow   (s_ovf),
    .no_signal  (s_nosig)
  );

  always #5 clk40 = ~clk40;

  // Square wave with half-period "half" cycles; half=0 leaves sig_in to the sequences
  initial begin
    forever begin
      @(posedge clk40);
      #3;
      if (half > 0) begin
        if (gen_c >= half - 1) begin
          sig_in = ~sig_in;
          gen_c  = 0;
        end else begin
          gen_c++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp);
    total++;
    if (act < exp - 1 || act > exp + 1) begin
      bad++;
      $display("FAIL %s: got %0d want %0d+-1", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    int k;
    n = -1;
    k = 0;
    while (n < 0 && k < max_cyc) begin
      @(posedge clk40);
      #2;
      k++;
      if (freq_valid) n = k;
    end
  endtask

  initial begin
    int n;
    int seen;

    vecs[0] = '{10,  50, 0, 0, 15, 1};
    vecs[1] = '{20,  25, 0, 0, 15, 1};
    vecs[2] = '{ 0,   0, 0, 1,  0, 0};
    vecs[3] = '{50,  10, 0, 0, 10, 0};
    vecs[4] = '{ 2, 250, 0, 0, 15, 1};
    vecs[5] = '{ 4, 125, 0, 0, 15, 1};

    repeat (3) @(posedge clk40);
    #2;
    check("rst_count", int'(freq_count), 0);
    check("rst_valid", int'(freq_valid), 0);
    check("rst_ovf",   int'(overflow), 0);
    check("rst_nosig", int'(no_signal), 0);
    check("rst_small_count", int'(s_count), 0);

    // First window after reset: latency and a period-20 input
    @(posedge clk40); #2;
    reset_n = 1'b1;
    half    = 10;
    @(posedge clk40); #2;
    enable = 1'b1;
    @(posedge clk40);
    wait_valid(1100, n);
    check("first_latency", n, GC + 1);
    check_near("first_count", int'(freq_count), 50);
    check("first_nosig", int'(no_signal), 0);
    check("first_ovf", int'(overflow), 0);
    @(posedge clk40); #2;
    check("valid_one_cycle", int'(freq_valid), 0);

    for (int i = 0; i < 6; i++) begin
      half = vecs[i].half;
      if (vecs[i].half == 0) sig_in = 1'b0;
      wait_valid(2100, n);
      check($sformatf("v%0d_settle", i), int'(n > 0), 1);
      wait_valid(1100, n);
      check($sformatf("v%0d_period", i), n, GC + 1);
      check_near($sformatf("v%0d_count", i), int'(freq_count), vecs[i].cnt);
      check($sformatf("v%0d_ovf", i), int'(overflow), vecs[i].ovf);
      check($sformatf("v%0d_nosig", i), int'(no_signal), vecs[i].nosig);
      check_near($sformatf("v%0d_small_count", i), int'(s_count), vecs[i].scnt);
      check($sformatf("v%0d_small_ovf", i), int'(s_ovf), vecs[i].sovf);
    end

    // Drain to IDLE with a quiet input
    enable = 1'b0;
    half   = 0;
    sig_in = 1'b0;
    wait_valid(1100, n);
    check("drain_done", int'(n > 0), 1);
    repeat (5) @(posedge clk40);
    #2;

    // Window A: single rise landing in the final RUN cycle
    enable = 1'b1;
    @(posedge clk40);
    repeat (GC - 3) @(posedge clk40);
    #2 sig_in = 1'b1;
    repeat (3) @(posedge clk40);
    #2 sig_in = 1'b0;
    @(posedge clk40); #2;
    check("lastrun_valid", int'(freq_valid), 1);
    check("lastrun_count", int'(freq_count), 1);
    check("lastrun_nosig", int'(no_signal), 0);

    // Window B: only rise falls in its LATCH cycle
    repeat (GC - 2) @(posedge clk40);
    #2 sig_in = 1'b1;
    repeat (3) @(posedge clk40);
    #2;
    check("latch_valid", int'(freq_valid), 1);
    check("latch_count", int'(freq_count), 0);
    check("latch_nosig", int'(no_signal), 1);

    // Window C: three pulses, enable dropped at cycle 300
    repeat (50) @(posedge clk40);
    #2 sig_in = 1'b0;
    for (int j = 0; j < 3; j++) begin
      repeat (10) @(posedge clk40);
      #2 sig_in = 1'b1;
      repeat (10) @(posedge clk40);
      #2 sig_in = 1'b0;
    end
    repeat (190) @(posedge clk40);
    #2 enable = 1'b0;
    wait_valid(800, n);
    check("drop_latency", n, GC + 1 - 300);
    check("drop_count", int'(freq_count), 3);
    check("drop_nosig", int'(no_signal), 0);
    check("drop_ovf", int'(overflow), 0);

    seen = 0;
    for (int j = 0; j < 1500; j++) begin
      @(posedge clk40); #2;
      if (freq_valid) seen = 1;
    end
    check("idle_no_valid", seen, 0);
    check("idle_hold_count", int'(freq_count), 3);
    check("idle_hold_nosig", int'(no_signal), 0);

    // Reset mid-window, then a clean restart
    enable = 1'b1;
    half   = 10;
    repeat (500) @(posedge clk40);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_count", int'(freq_count), 0);
    check("midrst_valid", int'(freq_valid), 0);
    check("midrst_ovf", int'(overflow), 0);
    check("midrst_nosig", int'(no_signal), 0);
    @(posedge clk40); #2;
    reset_n = 1'b1;
    @(posedge clk40);
    wait_valid(1100, n);
    check("restart_latency", n, GC + 1);
    check_near("restart_count", int'(freq_count), 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
